half_divide_sched: RTL

HALF_DIVIDE_SCHED -- requirements
Module: half_divide_sched

---
 rtl/half_pkg.sv | 17 +
 rtl/half_divide_sched_if.sv | 26 ++
 rtl/half_divide.sv | 128 ++++++++++++
 rtl/half_divide_sched.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/half_pkg.sv
// rtl/half_pkg.sv - shared half-precision types, constants and scheduler state enum
package half_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_POS_INF = 16'h7C00;
  localparam half_t HALF_NEG_INF = 16'hFC00;
  localparam half_t HALF_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/half_divide_sched_if.sv
// rtl/half_divide_sched_if.sv - job request / result bundle for half_divide_sched
interface half_divide_sched_if #(
  parameter int WIDTH = 10
);
  import half_pkg::*;

  logic              in_valid;
  logic              in_ready;
  half_t [WIDTH-1:0] vector_a;
  half_t             b;
  logic              out_valid;
  half_t [WIDTH-1:0] vector_c;
  logic              busy;
  logic              div_by_zero;

  modport master (
    output in_valid, vector_a, b,
    input  in_ready, out_valid, vector_c, busy, div_by_zero
  );

  modport slave (
    input  in_valid, vector_a, b,
    output in_ready, out_valid, vector_c, busy, div_by_zero
  );

endinterface

// File: rtl/half_divide.sv
// rtl/half_divide.sv - two-stage pipelined IEEE half-precision divider, c = a / b
module half_divide
  import half_pkg::*;
(
  input  logic  rstn,
  input  logic  clk,
  input  logic  in_valid,
  input  half_t a,
  input  half_t b,
  output logic  out_valid,
  output half_t c
);

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [24:0]       num, den;
  logic [14:0]       quo;
  logic              sticky;
  logic signed [7:0] exp_raw;
  kind_e             kind;

  // Subnormal operands are flushed to zero; only normals reach the mantissa divider.
  assign a_zero  = (a[14:10] == 5'd0);
  assign b_zero  = (b[14:10] == 5'd0);
  assign a_inf   = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
  assign b_inf   = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
  assign a_nan   = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
  assign b_nan   = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
  // 1.fa * 2^14 / 1.fb lies in (2^13, 2^15), so 15 quotient bits always suffice.
  assign num     = {1'b1, a[9:0], 14'd0};
  assign den     = {14'd0, 1'b1, b[9:0]};
  assign quo     = 15'(num / den);
  assign sticky  = ((num % den) != 25'd0);
  assign exp_raw = $signed({3'b000, a[14:10]}) - $signed({3'b000, b[14:10]}) + 8'sd15;

  // Classify special operand combinations with NaN taking precedence over Inf over zero.
  always_comb begin
    kind = K_NORM;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      kind = K_NAN;
    end else if (a_inf || b_zero) begin
      kind = K_INF;
    end else if (a_zero || b_inf) begin
      kind = K_ZERO;
    end
  end

  logic              s1_valid_q;
  kind_e             s1_kind_q;
  logic              s1_sign_q;
  logic [14:0]       s1_quo_q;
  logic              s1_sticky_q;
  logic signed [7:0] s1_exp_q;

  // Stage 1 register: classification, sign and raw quotient.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
    end
    s1_kind_q   <= kind;
    s1_sign_q   <= a[15] ^ b[15];
    s1_quo_q    <= quo;
    s1_sticky_q <= sticky;
    s1_exp_q    <= exp_raw;
  end

  logic [9:0]        frac;
  logic              guard, rest, round_up;
  logic [10:0]       frac_r;
  logic signed [7:0] exp_n, exp_r;
  half_t             res;

  // Normalise to 1.f, round to nearest even, then saturate to Inf or flush to zero.
  always_comb begin
    if (s1_quo_q[14]) begin
      frac  = s1_quo_q[13:4];
      guard = s1_quo_q[3];
      rest  = (|s1_quo_q[2:0]) | s1_sticky_q;
      exp_n = s1_exp_q;
    end else begin
      frac  = s1_quo_q[12:3];
      guard = s1_quo_q[2];
      rest  = (|s1_quo_q[1:0]) | s1_sticky_q;
      exp_n = s1_exp_q - 8'sd1;
    end
    round_up = guard & (rest | frac[0]);
    frac_r   = {1'b0, frac} + {10'd0, round_up};
    exp_r    = frac_r[10] ? (exp_n + 8'sd1) : exp_n;
    res      = HALF_QNAN;
    case (s1_kind_q)
      K_NAN:   res = HALF_QNAN;
      K_INF:   res = s1_sign_q ? HALF_NEG_INF : HALF_POS_INF;
      K_ZERO:  res = {s1_sign_q, 15'd0};
      default: begin
        if (exp_r >= 8'sd31) begin
          res = s1_sign_q ? HALF_NEG_INF : HALF_POS_INF;
        end else if (exp_r <= 8'sd0) begin
          res = {s1_sign_q, 15'd0};
        end else begin
          res = {s1_sign_q, exp_r[4:0], frac_r[9:0]};
        end
      end
    endcase
  end

  logic  s2_valid_q;
  half_t c_q;

  // Stage 2 register: packed result and its valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      c_q        <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_q <= res;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign c         = c_q;

endmodule

// File: rtl/half_divide_sched.sv
// rtl/half_divide_sched.sv - vector / scalar half divide, one shared divider; HALF_DIVIDE_SCHED_DBZ_EN enables zero-divisor bypass
module half_divide_sched
  import half_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input logic               clk,
  input logic               rstn,
  half_divide_sched_if.slave bus
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  half_t [WIDTH-1:0] vec_a_q;
  half_t [WIDTH-1:0] vector_c_q;
  half_t             b_q;
  logic              accept, res_wr, dbz_hit;
  logic              div_in_valid, div_out_valid;
  half_t             div_a, div_c;

`ifdef HALF_DIVIDE_SCHED_DBZ_EN
  logic              dbz_q;
  half_t [WIDTH-1:0] dbz_vec;

  assign dbz_hit = (bus.b[14:0] == 15'd0);

  // Bypass result: signed Inf per element, NaN where the dividend is also zero.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.vector_a[i][14:0] == 15'd0) begin
        dbz_vec[i] = HALF_QNAN;
      end else begin
        dbz_vec[i] = (bus.vector_a[i][15] ^ bus.b[15]) ? HALF_NEG_INF : HALF_POS_INF;
      end
    end
  end

  // Remember that the current job took the bypass so DONE can report it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dbz_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= dbz_hit;
    end
  end

  assign bus.div_by_zero = (state_q == S_DONE) && dbz_q;
`else
  assign dbz_hit         = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  // Next state, counters and divider strobe; a result write may override ISSUE->DRAIN.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    res_cnt_d    = res_cnt_q;
    accept       = 1'b0;
    res_wr       = 1'b0;
    div_in_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept      = 1'b1;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
          state_d     = dbz_hit ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_in_valid = 1'b1;
        if (issue_cnt_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Results arriving in IDLE/DONE are leftovers of an aborted job and are dropped.
    if (div_out_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN))) begin
      res_wr = 1'b1;
      if (res_cnt_q == LAST) begin
        state_d = S_DONE;
      end else begin
        res_cnt_d = res_cnt_q + 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Operand capture at accept and in-order result writes into vector_c.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vec_a_q    <= '0;
      b_q        <= '0;
      vector_c_q <= '0;
    end else begin
      if (accept) begin
        vec_a_q <= bus.vector_a;
        b_q     <= bus.b;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (res_wr && (res_cnt_q == CNT_W'(i))) begin
          vector_c_q[i] <= div_c;
        end
      end
`ifdef HALF_DIVIDE_SCHED_DBZ_EN
      if (accept && dbz_hit) begin
        vector_c_q <= dbz_vec;
      end
`endif
    end
  end

  // Element select for the shared divider.
  always_comb begin
    div_a = vec_a_q[0];
    for (int i = 0; i < WIDTH; i++) begin
      if (issue_cnt_q == CNT_W'(i)) begin
        div_a = vec_a_q[i];
      end
    end
  end

  half_divide u_div (
    .rstn      (rstn),
    .clk       (clk),
    .in_valid  (div_in_valid),
    .a         (div_a),
    .b         (b_q),
    .out_valid (div_out_valid),
    .c         (div_c)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.vector_c  = vector_c_q;

endmodule
